cc_frame_io: RTL

- Sequential front/back-end wrapped around the combinational CC (Chinese Course) ranking core.
- Collects seven 4-bit student scores serially, plus the opt/a/b control fields, and presents them as stable parallel registers to CC.
- After a programmable settle window, captures CC's s_id0..s_id6 and out results.
- Streams those results back out serially, one 3-bit word per cycle.

---
 rtl/cc_frame_io_if.sv | 26 ++
 rtl/cc_frame_io.sv | 136 +++++++++++++
 2 files changed

// File: rtl/cc_frame_io_if.sv
// Score/control input beats and serial result stream of cc_frame_io.
// master = frame source and result sink, slave = cc_frame_io.
interface cc_frame_io_if #(
  parameter int unsigned SCORE_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [SCORE_W-1:0] in_score;
  logic [2:0]         in_opt;
  logic [1:0]         in_a;
  logic [2:0]         in_b;
  logic               out_valid;
  logic               out_last;
  logic [2:0]         out_data;
  logic               err;

  modport master (
    output in_valid, in_score, in_opt, in_a, in_b,
    input  in_ready, out_valid, out_last, out_data, err
  );

  modport slave (
    input  in_valid, in_score, in_opt, in_a, in_b,
    output in_ready, out_valid, out_last, out_data, err
  );
endinterface

// File: rtl/cc_frame_io.sv
// Serial-in / serial-out wrapper around the combinational CC ranking core:
// loads seven scores, holds them stable for EVAL_WAIT cycles, then streams eight result words.
module cc_frame_io #(
  parameter int unsigned SCORE_W   = 4,
  parameter int unsigned EVAL_WAIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  cc_frame_io_if.slave       bus,
  output logic [SCORE_W-1:0] cc_in_s0,
  output logic [SCORE_W-1:0] cc_in_s1,
  output logic [SCORE_W-1:0] cc_in_s2,
  output logic [SCORE_W-1:0] cc_in_s3,
  output logic [SCORE_W-1:0] cc_in_s4,
  output logic [SCORE_W-1:0] cc_in_s5,
  output logic [SCORE_W-1:0] cc_in_s6,
  output logic [2:0]         cc_opt,
  output logic [1:0]         cc_a,
  output logic [2:0]         cc_b,
  input  logic [2:0]         cc_s_id0,
  input  logic [2:0]         cc_s_id1,
  input  logic [2:0]         cc_s_id2,
  input  logic [2:0]         cc_s_id3,
  input  logic [2:0]         cc_s_id4,
  input  logic [2:0]         cc_s_id5,
  input  logic [2:0]         cc_s_id6,
  input  logic [2:0]         cc_out
);
  localparam int unsigned NUM_S   = 7;
  localparam int unsigned NUM_OUT = 8;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned WAIT_W  = $clog2(EVAL_WAIT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, EVAL, SEND} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   idx;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [SCORE_W-1:0] score_q [NUM_S];
  logic [2:0]         res_q   [NUM_OUT];

  assign cc_in_s0 = score_q[0];
  assign cc_in_s1 = score_q[1];
  assign cc_in_s2 = score_q[2];
  assign cc_in_s3 = score_q[3];
  assign cc_in_s4 = score_q[4];
  assign cc_in_s5 = score_q[5];
  assign cc_in_s6 = score_q[6];

  // Frame FSM; err defaults low and pulses only on the offending cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      wait_cnt      <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= '0;
      bus.err       <= 1'b0;
      cc_opt        <= '0;
      cc_a          <= '0;
      cc_b          <= '0;
      for (int i = 0; i < NUM_S; i++)   score_q[i] <= '0;
      for (int i = 0; i < NUM_OUT; i++) res_q[i]   <= '0;
    end else begin
      bus.err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            score_q[0] <= bus.in_score;
            cc_opt     <= bus.in_opt;
            cc_a       <= bus.in_a;
            cc_b       <= bus.in_b;
            cnt        <= CNT_W'(1);
            state      <= LOAD;
          end
        end
        LOAD: begin
          if (bus.in_valid) begin
            score_q[cnt] <= bus.in_score;
            if (cnt == CNT_W'(NUM_S - 1)) begin
              cnt          <= '0;
              wait_cnt     <= '0;
              bus.in_ready <= 1'b0;
              state        <= EVAL;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            // Gap mid-frame: drop the partial frame, stored scores are left stale.
            bus.err <= 1'b1;
            cnt     <= '0;
            state   <= IDLE;
          end
        end
        EVAL: begin
          bus.err <= bus.in_valid;
          if (wait_cnt == WAIT_W'(EVAL_WAIT)) begin
            res_q[0]      <= cc_s_id0;
            res_q[1]      <= cc_s_id1;
            res_q[2]      <= cc_s_id2;
            res_q[3]      <= cc_s_id3;
            res_q[4]      <= cc_s_id4;
            res_q[5]      <= cc_s_id5;
            res_q[6]      <= cc_s_id6;
            res_q[7]      <= cc_out;
            bus.out_valid <= 1'b1;
            bus.out_data  <= cc_s_id0;
            idx           <= '0;
            state         <= SEND;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        SEND: begin
          bus.err <= bus.in_valid;
          if (idx == CNT_W'(NUM_OUT - 1)) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_data  <= '0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end else begin
            idx          <= idx + CNT_W'(1);
            bus.out_data <= res_q[idx + CNT_W'(1)];
            bus.out_last <= (idx == CNT_W'(NUM_OUT - 2));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
